// File: rtl/mips_store_pkg.sv
// mips_store_pkg: shared store-path encodings (size codes, lane width, RMW states) and misalignment rule
package mips_store_pkg;
  localparam int LANE_W = 8;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_ERR} state_t;
  // size 11 is reserved and always rejected
  function automatic logic misaligned(logic [1:0] size, logic [1:0] off);
    return size == SZ_HALF ? off[0] : size == SZ_WORD ? off != 2'b00 : size != SZ_BYTE;
  endfunction
endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: big-endian merge of a byte/half/word store into an old memory word
// i_old: word read from memory; i_data: register value, low bits stored
// i_size: SZ_BYTE/SZ_HALF/SZ_WORD; i_off: byte address bits [1:0]; o_word: merged word
module store_lane_merge
  import mips_store_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  output logic [31:0] o_word
);
  // ~off maps byte offset 0 to the most significant lane
  always_comb begin
    o_word = i_old;
    if (i_size == SZ_BYTE) o_word[{~i_off, 3'b000} +: LANE_W] = i_data[LANE_W-1:0];
    else if (i_size == SZ_HALF) o_word[{~i_off[1], 4'b0000} +: 2*LANE_W] = i_data[2*LANE_W-1:0];
    else o_word = i_data;
  end
endmodule

// File: rtl/store_merge_rmw.sv
// store_merge_rmw: narrows a register store to byte/half/word and writes it via read-modify-write
// clk/rst_n: clock, async active-low reset
// req_valid/req_ready/req_addr/req_data/req_size: store request, ready only when idle
// done/misalign: completion pulse, misalign marks a rejected request
// mem_addr/mem_rd_en/mem_rdata/mem_wr_en/mem_wdata: word-addressed memory port without byte enables
module store_merge_rmw
  import mips_store_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              misalign,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata
);
  state_t r_state;
  logic [DATA_W-1:0] r_data;
  logic [1:0] r_size;
  logic [1:0] r_off;
  logic [1:0] r_cnt;
  logic [DATA_W-1:0] w_merged;
  assign req_ready = r_state == S_IDLE;
  store_lane_merge u_merge (
    .i_old (mem_rdata),
    .i_data(r_data),
    .i_size(r_size),
    .i_off (r_off),
    .o_word(w_merged)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_size    <= '0;
      r_off     <= '0;
      r_cnt     <= '0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done      <= 1'b0;
      misalign  <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_data   <= req_data;
          r_size   <= req_size;
          r_off    <= req_addr[1:0];
          mem_addr <= req_addr[ADDR_W-1:2];
          if (misaligned(req_size, req_addr[1:0])) begin
            r_state  <= S_ERR;
            done     <= 1'b1;
            misalign <= 1'b1;
          end else if (req_size == SZ_WORD) begin
            r_state   <= S_WRITE;
            mem_wr_en <= 1'b1;
            mem_wdata <= req_data;
            done      <= 1'b1;
          end else begin
            r_state   <= S_READ;
            mem_rd_en <= 1'b1;
          end
        end
        S_READ: begin
          r_state <= S_WAIT;
          r_cnt   <= 2'(MEM_LAT - 1);
        end
        // read data is valid in the last WAIT cycle; merge it straight into the write word
        S_WAIT: if (r_cnt == 2'd0) begin
          r_state   <= S_WRITE;
          mem_wr_en <= 1'b1;
          mem_wdata <= w_merged;
          done      <= 1'b1;
        end else r_cnt <= r_cnt - 2'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_merge_rmw.sv
// tb_store_merge_rmw: randomized and directed bench for store_merge_rmw at MEM_LAT 1 and 3
module tb_store_merge_rmw;
  int checks = 0;
  int errors = 0;
  int n_fin = 0;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(int lat, string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lat%0d %s: got %h expected %h", lat, nm, act, exp);
    end
  endtask

  task automatic chkb(int lat, string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lat%0d %s: got %b expected %b", lat, nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(int k);
    if (k == 0) return 32'h55555555;
    if (k == 2 || k == 3 || k == 5 || k == 6) return 32'h11223344;
    return 32'h9E3779B9 ^ (32'(k) * 32'h01010101);
  endfunction

  // byte offset o occupies bits 31-8*o down; half h occupies bits 31-16*h down
  function automatic logic [31:0] model_store(logic [31:0] old, logic [31:0] d, logic [1:0] sz, logic [1:0] off);
    logic [31:0] w;
    w = old;
    if (sz == 2'd0) w[31 - 8 * int'(off) -: 8] = d[7:0];
    else if (sz == 2'd1) w[31 - 16 * int'(off[1]) -: 16] = d[15:0];
    else w = d;
    return w;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int LAT = g == 0 ? 1 : 3;
    logic rst_n, req_valid, req_ready, done, misalign, mem_rd_en, mem_wr_en;
    logic [31:0] req_addr, req_data, mem_rdata, mem_wdata;
    logic [1:0] req_size;
    logic [29:0] mem_addr;
    logic [31:0] mem [0:15];
    logic [31:0] ref_mem [0:15];
    logic hv [0:3];
    logic [29:0] ha [0:3];
    int cyc = 0;
    int free_at, t_acc, t_rd, t_wr, t_done;
    logic exp_mis;
    logic [31:0] exp_wdata;
    logic [29:0] exp_addr;
    int last_done = 0, n_rd = 0, n_wr = 0, n_done = 0, acc_cyc = 0;
    logic last_mis = 1'b0;
    logic [31:0] last_wdata = '0;
    logic [29:0] last_waddr = '0;

    store_merge_rmw #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(LAT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr (req_addr),
      .req_data (req_data),
      .req_size (req_size),
      .done     (done),
      .misalign (misalign),
      .mem_addr (mem_addr),
      .mem_rd_en(mem_rd_en),
      .mem_rdata(mem_rdata),
      .mem_wr_en(mem_wr_en),
      .mem_wdata(mem_wdata)
    );

    // memory: 16 words indexed by mem_addr[3:0], read data valid LAT cycles after the strobe
    always @(posedge clk) begin
      if (cyc == 0) for (int k = 0; k < 16; k++) mem[k] <= init_word(k);
      else if (mem_wr_en) mem[mem_addr[3:0]] <= mem_wdata;
      for (int k = 3; k > 0; k--) begin
        hv[k] <= hv[k-1];
        ha[k] <= ha[k-1];
      end
      hv[0] <= mem_rd_en;
      ha[0] <= mem_addr;
    end
    assign mem_rdata = hv[LAT-1] ? mem[ha[LAT-1][3:0]] : 32'hBAD0BAD0;

    // transaction-level model: each accepted request yields a timeline of expected events
    always @(negedge clk) begin : cmp
      logic [1:0] off;
      cyc++;
      if (cyc == 1) for (int k = 0; k < 16; k++) ref_mem[k] = init_word(k);
      if (!rst_n) begin
        chkb(LAT, "reset req_ready", req_ready, 1'b1);
        chkb(LAT, "reset done", done, 1'b0);
        chkb(LAT, "reset misalign", misalign, 1'b0);
        chkb(LAT, "reset mem_rd_en", mem_rd_en, 1'b0);
        chkb(LAT, "reset mem_wr_en", mem_wr_en, 1'b0);
        chk(LAT, "reset mem_addr", {2'b00, mem_addr}, 32'd0);
        chk(LAT, "reset mem_wdata", mem_wdata, 32'd0);
        free_at = 0;
        t_acc = -1;
        t_rd = -1;
        t_wr = -1;
        t_done = -1;
        exp_mis = 1'b0;
      end else begin
        chkb(LAT, "req_ready", req_ready, cyc >= free_at);
        chkb(LAT, "mem_rd_en", mem_rd_en, cyc == t_rd);
        chkb(LAT, "mem_wr_en", mem_wr_en, cyc == t_wr);
        chkb(LAT, "done", done, cyc == t_done);
        chkb(LAT, "misalign", misalign, cyc == t_done && exp_mis);
        if (cyc == t_wr) begin
          chk(LAT, "mem_wdata", mem_wdata, exp_wdata);
          ref_mem[exp_addr[3:0]] = exp_wdata;
        end
        if (t_acc >= 0 && cyc > t_acc && cyc <= t_done) chk(LAT, "mem_addr", {2'b00, mem_addr}, {2'b00, exp_addr});
        if (req_valid && cyc >= free_at) begin
          t_acc = cyc;
          exp_addr = req_addr[31:2];
          off = req_addr[1:0];
          t_done = cyc + 1;
          free_at = cyc + 2;
          t_rd = -1;
          t_wr = -1;
          exp_mis = req_size == 2'd3 || (req_size == 2'd1 && off[0]) || (req_size == 2'd2 && off != 2'd0);
          if (!exp_mis && req_size == 2'd2) begin
            t_wr = cyc + 1;
            exp_wdata = req_data;
          end else if (!exp_mis) begin
            t_rd = cyc + 1;
            t_wr = cyc + 2 + LAT;
            t_done = t_wr;
            free_at = cyc + 3 + LAT;
            exp_wdata = model_store(ref_mem[req_addr[5:2]], req_data, req_size, off);
          end
        end
      end
      if (done) begin
        n_done++;
        last_done = cyc;
        last_mis = misalign;
      end
      if (mem_rd_en) n_rd++;
      if (mem_wr_en) begin
        n_wr++;
        last_wdata = mem_wdata;
        last_waddr = mem_addr;
      end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      logic ok;
      ok = 1'b0;
      req_valid = 1'b1;
      req_addr = a;
      req_data = d;
      req_size = s;
      for (int k = 0; k < 40 && !ok; k++) begin
        @(negedge clk);
        ok = req_ready;
        @(posedge clk);
        if (ok) acc_cyc = cyc;
        #1;
      end
      if (!ok) chkb(LAT, "accept timeout", 1'b0, 1'b1);
      req_valid = 1'b0;
      req_addr = $urandom;
      req_data = $urandom;
      req_size = 2'($urandom);
    endtask

    task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
        @(negedge clk);
        ok = req_ready;
      end
      if (!ok) chkb(LAT, "idle timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1;
    endtask

    initial begin
      int rd0, wr0, dn0;
      int acc [4];
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_addr = '0;
      req_data = '0;
      req_size = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd0 = n_rd;
      store(32'h0000_0010, 32'hDEADBEEF, 2'd2);
      wait_idle();
      chk(LAT, "word latency", last_done - acc_cyc, 1);
      chk(LAT, "word wdata", last_wdata, 32'hDEADBEEF);
      chk(LAT, "word addr", {2'b00, last_waddr}, 32'h4);
      chk(LAT, "word no read", n_rd - rd0, 0);
      rd0 = n_rd;
      store(32'h0000_000A, 32'hFFFFFFAB, 2'd0);
      wait_idle();
      chk(LAT, "byte latency", last_done - acc_cyc, LAT + 2);
      chk(LAT, "byte wdata", last_wdata, 32'h1122AB44);
      chk(LAT, "byte one read", n_rd - rd0, 1);
      store(32'h0000_000E, 32'h0000CAFE, 2'd1);
      wait_idle();
      chk(LAT, "half lo wdata", last_wdata, 32'h1122CAFE);
      store(32'h0000_0014, 32'h0000CAFE, 2'd1);
      wait_idle();
      chk(LAT, "half hi wdata", last_wdata, 32'hCAFE3344);
      for (int k = 0; k < 3; k++) begin
        rd0 = n_rd;
        wr0 = n_wr;
        store(k == 0 ? 32'h1 : k == 1 ? 32'h2 : 32'h0, 32'h12345678, k == 0 ? 2'd1 : k == 1 ? 2'd2 : 2'd3);
        wait_idle();
        chk(LAT, "misalign latency", last_done - acc_cyc, 1);
        chkb(LAT, "misalign flag", last_mis, 1'b1);
        chk(LAT, "misalign no strobes", (n_rd - rd0) + (n_wr - wr0), 0);
      end
      store(32'h0000_0018, 32'h00000077, 2'd0);
      @(posedge clk);
      #1;
      wr0 = n_wr;
      dn0 = n_done;
      rst_n = 1'b0;
      #1;
      chkb(LAT, "abort req_ready", req_ready, 1'b1);
      chkb(LAT, "abort done", done, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (LAT + 4) @(posedge clk);
      #1;
      chk(LAT, "abort no write", n_wr - wr0, 0);
      chk(LAT, "abort no done", n_done - dn0, 0);
      chk(LAT, "abort mem kept", mem[6], 32'h11223344);
      store(32'h0000_0019, 32'hFFFFFF99, 2'd0);
      wait_idle();
      chk(LAT, "after abort wdata", last_wdata, 32'h11993344);
      for (int k = 0; k < 4; k++) begin
        store(32'(k), 32'hA1 + 32'(k), 2'd0);
        acc[k] = acc_cyc;
      end
      wait_idle();
      for (int k = 1; k < 4; k++) chk(LAT, "b2b spacing", acc[k] - acc[k-1], LAT + 3);
      chk(LAT, "lanes final word", mem[0], 32'hA1A2A3A4);
      repeat (60) begin
        store($urandom, $urandom, 2'($urandom));
        if ($urandom_range(0, 1) == 1) wait_idle();
      end
      wait_idle();
      for (int k = 0; k < 16; k++) chk(LAT, "final memory", mem[k], ref_mem[k]);
      n_fin++;
    end
  end

  initial begin
    for (int k = 0; k < 20000 && n_fin < 2; k++) @(posedge clk);
    if (n_fin < 2) begin
      checks++;
      errors++;
      $display("FAIL global timeout: got %0d finished instances expected 2", n_fin);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_merge_rmw.md
Name: store_merge_rmw

Overview:
- Store-side counterpart of the load-path sign extender: narrows a 32-bit register value to byte/halfword/word and writes it into word-addressed data memory that has no byte enables.
- Sub-word stores use a read-modify-write sequence: read word, merge lane(s), write word back.
- Sits between EX/MEM store request and the data memory port; stalls the pipeline through `req_ready`.

Parameters:
- `DATA_W`, 32, data word width (fixed 32 for MIPS32; lanes are 8 bits).
- `ADDR_W`, 32, byte address width; memory word address is `ADDR_W-2` bits.
- `MEM_LAT`, 1, cycles from `mem_rd_en` to valid `mem_rdata` (legal range 1..4).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  store request valid.
- `req_ready`  out  1  block idle, can accept request.
- `req_addr`  in  `ADDR_W`  byte address.
- `req_data`  in  `DATA_W`  register value (rt); low bits are stored.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `done`  out  1  one-cycle pulse, store complete (or rejected).
- `misalign`  out  1  one-cycle pulse with `done`: request rejected, no memory write.
- `mem_addr`  out  `ADDR_W-2`  word address = latched `req_addr[ADDR_W-1:2]`.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_rdata`  in  `DATA_W`  memory read data.
- `mem_wr_en`  out  1  memory write strobe.
- `mem_wdata`  out  `DATA_W`  merged write word.

Behaviour:
- States: IDLE, READ, WAIT, WRITE, ERR.
- `req_ready` = (state==IDLE), combinational from state; therefore 1 during and after reset.
- On reset:
  - state=IDLE.
  - `done`, `misalign`, `mem_rd_en`, `mem_wr_en` = 0.
  - `mem_addr`, `mem_wdata` and internal latches = 0.
  - Wait counter = 0.
- Accept when `req_valid && req_ready` in cycle T: latch addr, data, size.
- Misaligned means any of:
  - size=01 with `addr[0]`=1;
  - size=10 with `addr[1:0]`≠0;
  - size=11.
  A misaligned request goes to ERR. In T+1: `done`=`misalign`=1, no memory strobes. Then IDLE.
- Word store goes directly to WRITE. In T+1: `mem_wr_en`=1, `mem_wdata`=`req_data`, `done`=1. Then IDLE.
- Byte or halfword store:
  - T+1: READ, `mem_rd_en`=1 for exactly one cycle.
  - WAIT counts `MEM_LAT` cycles.
  - `mem_rdata` is sampled in cycle T+1+`MEM_LAT`.
  - T+2+`MEM_LAT`: WRITE, `mem_wr_en`=1, `done`=1.
  - Total latency for `MEM_LAT`=1 is 3 cycles, accept to done.
- Lane mapping is big-endian:
  - byte lane for `addr[1:0]`=0/1/2/3 is bits [31:24]/[23:16]/[15:8]/[7:0];
  - half lane for `addr[1]`=0/1 is bits [31:16]/[15:0].
- Merge takes `req_data[7:0]` or `req_data[15:0]` into the selected lane. All other bits come from `mem_rdata` unchanged. Upper bits of `req_data` are ignored (truncation, no overflow check).
- `mem_addr` is held stable from T+1 until WRITE completes. `mem_rd_en` and `mem_wr_en` are never high together.
- Back-to-back: `req_ready`=1 in the cycle after `done`, so the next accept is at done+1.
- `req_valid` while busy is ignored and not latched. Upstream holds the request.
- Reset mid-operation aborts immediately: no write, no `done`. The request is lost and upstream must re-issue.
- All outputs except `req_ready` are registered.

Decomposition:
- Shared package `mips_store_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - state encoding constants;
  - `LANE_W`=8.
- One combinational sub-module, `store_lane_merge`: inputs old word, `req_data`, size, `addr[1:0]`; output merged word. It is reused by any future store buffer.

Test Plan:
- Word store: addr 0x0000_0010, data 0xDEADBEEF, size 10 -> T+1 `mem_wr_en`=1, `mem_addr`=0x4, `mem_wdata`=0xDEADBEEF, `done`=1, no `mem_rd_en`.
- Byte store: mem word 0x11223344, addr 0x...02, data 0xFFFFFFAB, size 00 -> one `mem_rd_en`, write 0x1122AB44 at T+3 (`MEM_LAT`=1).
- Half store: mem 0x11223344, addr 0x...02, data 0x0000CAFE, size 01 -> write 0x1122CAFE; at addr 0x...00 -> 0xCAFE3344.
- Misaligned: half at addr 0x...01, and word at 0x...02 -> `done`=`misalign`=1 at T+1, no memory strobes; size 11 behaves the same.
- Reset mid-RMW: assert `rst_n`=0 during WAIT -> no `mem_wr_en`, no `done`, `req_ready`=1, outputs 0; a new byte store afterwards completes correctly.
- `MEM_LAT`=3 plus back-to-back byte stores to all 4 lanes of one word starting 0x00000000, data 0xA1..0xA4 -> final word 0xA1A2A3A4, accept spacing = latency+1.
